bcd_convert_seq: RTL and testbench
==================================

Name: bcd_convert_seq

Overview:
Multi-cycle binary-to-BCD sequencer for the adder display path.
- Converts a WIDTH-bit unsigned sum into DIGITS packed BCD digits.
- Uses iterative shift-and-add-3 (double dabble), one bit per clock.
- Sits between the adder result register and the seven-segment decoders.
- Start/busy/done handshake lets the top-level controller schedule conversions and hold displays stable.

Parameters:
- WIDTH, 8, bit width of the binary input (1..16).
- DIGITS, 3, number of BCD output digits (1..5).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a conversion; sampled on a rising clk edge.
- bin_in  input  WIDTH  binary value; captured on the edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd_out is updated.
- bcd_out  output  4*DIGITS  packed BCD, digit 0 (ones) in [3:0]; holds the last result.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, busy=0, done=0, bcd_out=0, iteration counter=0, internal shift register=0.
  - Reset takes effect immediately, including mid-conversion. The partial result is discarded; bcd_out stays 0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1 at an edge: capture bin_in into the low WIDTH bits of the shift register, clear the BCD field, load counter=WIDTH, go to SHIFT.
  - Otherwise remain in IDLE.
- SHIFT, each edge:
  - Every BCD nibble with value >=5 gets +3 (all nibbles evaluated in parallel, same cycle).
  - Then shift the whole {BCD, binary} register left by 1 and decrement the counter.
  - When the counter reaches 1 at the edge, this is the last shift: go to DONE and register the resulting BCD field into bcd_out on that same edge.
- DONE:
  - Lasts exactly one cycle with done=1. Next edge returns to IDLE.
  - A start=1 seen at that edge is accepted (back-to-back conversion). The next state is SHIFT with the new operand captured.
- busy=1 in SHIFT only; done=1 in DONE only. busy and done are never both 1.
- Latency: start accepted at edge k, then done=1 in the cycle following edge k+WIDTH. Throughput is one conversion per WIDTH+1 cycles.
- start while busy=1 is ignored; no queuing. bin_in changes while busy have no effect.
- bcd_out changes only on the edge entering DONE (or on reset). It is stable at all other times.
- Width rule: if the value exceeds 10^DIGITS-1, the upper digits are truncated, so the result is the value modulo 10^DIGITS (base behaviour).
- WIDTH=1: single SHIFT cycle, done in the cycle after edge k+1.

Optional Feature:
- Macro: BCD_SEQ_OVF_DETECT_EN.
- Defined:
  - Adds output port ovf (1 bit, reset 0).
  - ovf is registered on the same edge as bcd_out and held until the next result.
  - ovf=1 iff the captured value >= 10^DIGITS. In that case bcd_out saturates to all digits = 9.
- Undefined: no ovf port; truncation as in Behaviour.

Test Plan:
- WIDTH=8, DIGITS=3, bin_in=255, start pulse → busy=1 for 8 cycles, then done=1 for one cycle with bcd_out=0x255. Repeat with 0 → 0x000 and 99 → 0x099.
- Convert 200, then pulse start=1 again during busy with bin_in=7 → second start ignored; done once with bcd_out=0x200; no second done.
- Hold start=1 continuously with bin_in=42 → done pulses every 9 cycles, each with bcd_out=0x042; busy=0 only in done cycles.
- Start conversion of 123, assert rst_n=0 on cycle 4 of SHIFT → busy, done and bcd_out go to 0 immediately. After release, state is IDLE; converting 123 again gives 0x123.
- DIGITS=2, bin_in=100, macro undefined → bcd_out=0x00. Macro defined → ovf=1, bcd_out=0x99. Then bin_in=57 → ovf=0, bcd_out=0x57.
- WIDTH=4, DIGITS=2: sweep 0..15 → bcd_out matches {tens,ones}, e.g. 15 → 0x15, with done 5 cycles after each start.

Source files
------------

// File: rtl/bcd_convert_seq.sv
// bcd_convert_seq: multi-cycle binary-to-BCD converter for the adder display path.
// Runs shift-and-add-3 (double dabble) one bit per clock behind a start/busy/done handshake.
// Values above 10^DIGITS-1 keep only the low DIGITS digits (the result is value mod 10^DIGITS).
// Optional macro BCD_SEQ_OVF_DETECT_EN adds an 'ovf' output and saturates bcd_out to all nines.

module bcd_convert_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out
`ifdef BCD_SEQ_OVF_DETECT_EN
   ,
   output logic                  ovf
`endif
);

   localparam int SR_W  = 4*DIGITS + WIDTH;
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t               state_q;
   logic [SR_W-1:0]      shiftReg_q;
   logic [SR_W-1:0]      adjusted_d;
   logic [SR_W-1:0]      shiftReg_d;
   logic [CNT_W-1:0]     count_q;
   logic                 busy_q;
   logic                 done_q;
   logic [4*DIGITS-1:0]  bcdOut_q;

`ifdef BCD_SEQ_OVF_DETECT_EN
   // A carry out of the top digit means the partial value has left the representable range;
   // once that happens the value only grows, so the flag is sticky for the whole conversion.
   logic ovfAcc_q;
   logic ovfNext_d;
   logic ovf_q;
   assign ovfNext_d = ovfAcc_q | adjusted_d[SR_W-1];
   assign ovf       = ovf_q;
`endif

   assign busy    = busy_q;
   assign done    = done_q;
   assign bcd_out = bcdOut_q;

   // One double-dabble step: correct every digit >= 5 in parallel, then shift the whole register left.
   always_comb begin
      adjusted_d = shiftReg_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (adjusted_d[WIDTH + 4*i +: 4] >= 4'd5) begin
            adjusted_d[WIDTH + 4*i +: 4] = adjusted_d[WIDTH + 4*i +: 4] + 4'd3;
         end
      end
      shiftReg_d = adjusted_d << 1;
   end

   // Sequencer: capture operand on start, run WIDTH shift steps, publish the result for one done cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         shiftReg_q <= '0;
         count_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         bcdOut_q   <= '0;
`ifdef BCD_SEQ_OVF_DETECT_EN
         ovfAcc_q   <= 1'b0;
         ovf_q      <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  shiftReg_q <= {{(4*DIGITS){1'b0}}, bin_in};
                  count_q    <= CNT_W'(WIDTH);
                  busy_q     <= 1'b1;
                  state_q    <= SHIFT;
`ifdef BCD_SEQ_OVF_DETECT_EN
                  ovfAcc_q   <= 1'b0;
`endif
               end else begin
                  state_q <= IDLE;
               end
            end
            SHIFT: begin
               shiftReg_q <= shiftReg_d;
               count_q    <= count_q - CNT_W'(1);
`ifdef BCD_SEQ_OVF_DETECT_EN
               ovfAcc_q   <= ovfNext_d;
`endif
               if (count_q == CNT_W'(1)) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
`ifdef BCD_SEQ_OVF_DETECT_EN
                  ovf_q    <= ovfNext_d;
                  bcdOut_q <= ovfNext_d ? {DIGITS{4'h9}} : shiftReg_d[SR_W-1 -: 4*DIGITS];
`else
                  bcdOut_q <= shiftReg_d[SR_W-1 -: 4*DIGITS];
`endif
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_convert_seq.sv
// tb_bcd_convert_seq: scoreboard bench for bcd_convert_seq.
// Instance A uses WIDTH=8/DIGITS=3, instance B uses WIDTH=7/DIGITS=2 so values 100..127 exceed the digit range.
// Honours BCD_SEQ_OVF_DETECT_EN: when defined, the ovf ports are connected and saturation is expected.

module tb_bcd_convert_seq;

   localparam int WA = 8;
   localparam int DA = 3;
   localparam int WB = 7;
   localparam int DB = 2;

   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic startA = 1'b0;
   logic startB = 1'b0;
   logic [WA-1:0] binA = '0;
   logic [WB-1:0] binB = '0;
   logic busyA, doneA, busyB, doneB;
   logic [4*DA-1:0] bcdA;
   logic [4*DB-1:0] bcdB;
`ifdef BCD_SEQ_OVF_DETECT_EN
   logic ovfA, ovfB;
`endif

   int checks = 0;
   int errors = 0;

   // Expected results: bits [15:0] hold packed BCD, bit 16 holds the expected ovf flag.
   logic [31:0] qA[$];
   logic [31:0] qB[$];

   logic        mBusyA = 1'b0, mDoneA = 1'b0, mBusyB = 1'b0, mDoneB = 1'b0;
   int          mCntA  = 0, mCntB = 0;
   logic [31:0] mResA  = '0, mResB = '0;

   always #5 clk = ~clk;

   bcd_convert_seq #(.WIDTH(WA), .DIGITS(DA)) dutA (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (startA),
      .bin_in  (binA),
      .busy    (busyA),
      .done    (doneA),
      .bcd_out (bcdA)
`ifdef BCD_SEQ_OVF_DETECT_EN
      ,
      .ovf     (ovfA)
`endif
   );

   bcd_convert_seq #(.WIDTH(WB), .DIGITS(DB)) dutB (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (startB),
      .bin_in  (binB),
      .busy    (busyB),
      .done    (doneB),
      .bcd_out (bcdB)
`ifdef BCD_SEQ_OVF_DETECT_EN
      ,
      .ovf     (ovfB)
`endif
   );

   // Counts one comparison and reports it if the observed value differs from the expected one.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Decimal reference: low 'digits' decimal digits of v, or all nines plus ovf when saturation is enabled.
   function automatic logic [31:0] expectVal(input int v, input int digits);
      logic [31:0] r;
      int x;
      r = '0;
      x = v;
`ifdef BCD_SEQ_OVF_DETECT_EN
      begin
         int lim;
         lim = 1;
         for (int i = 0; i < digits; i++) lim = lim * 10;
         if (v >= lim) begin
            for (int i = 0; i < digits; i++) r[4*i +: 4] = 4'h9;
            r[16] = 1'b1;
            return r;
         end
      end
`endif
      for (int i = 0; i < digits; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Pulses start for one cycle on the selected instance, then lets 'cycles' clock edges pass.
   task automatic applyStimulus(input int sel, input int value, input int cycles);
      @(posedge clk);
      #1;
      if (sel == 0) begin
         startA = 1'b1;
         binA   = value[WA-1:0];
      end else begin
         startB = 1'b1;
         binB   = value[WB-1:0];
      end
      @(posedge clk);
      #1;
      startA = 1'b0;
      startB = 1'b0;
      repeat (cycles) @(posedge clk);
   endtask

   // Reference handshake for A: accepts start when not converting and pushes the expected result.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mBusyA <= 1'b0;
         mDoneA <= 1'b0;
         mCntA  <= 0;
         qA.delete();
      end else if (mBusyA) begin
         mCntA <= mCntA - 1;
         if (mCntA == 1) begin
            mBusyA <= 1'b0;
            mDoneA <= 1'b1;
         end
      end else begin
         mDoneA <= 1'b0;
         if (startA) begin
            qA.push_back(expectVal(int'(binA), DA));
            mBusyA <= 1'b1;
            mCntA  <= WA;
         end
      end
   end

   // Reference handshake for B, same rules with its own width.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mBusyB <= 1'b0;
         mDoneB <= 1'b0;
         mCntB  <= 0;
         qB.delete();
      end else if (mBusyB) begin
         mCntB <= mCntB - 1;
         if (mCntB == 1) begin
            mBusyB <= 1'b0;
            mDoneB <= 1'b1;
         end
      end else begin
         mDoneB <= 1'b0;
         if (startB) begin
            qB.push_back(expectVal(int'(binB), DB));
            mBusyB <= 1'b1;
            mCntB  <= WB;
         end
      end
   end

   // Mid-cycle checker: handshake every cycle, scoreboard pop on each done, held result otherwise.
   always @(negedge clk or negedge rst_n) begin : chk
      logic [31:0] expA;
      logic [31:0] expB;
      if (!rst_n) begin
         mResA <= '0;
         mResB <= '0;
      end else begin
         expA = mResA;
         expB = mResB;
         checkOutput("busyA", 32'(busyA), 32'(mBusyA));
         checkOutput("doneA", 32'(doneA), 32'(mDoneA));
         checkOutput("busyB", 32'(busyB), 32'(mBusyB));
         checkOutput("doneB", 32'(doneB), 32'(mDoneB));
         if (doneA) begin
            checkOutput("pendingA", 32'(qA.size() > 0), 32'd1);
            if (qA.size() > 0) expA = qA.pop_front();
         end
         if (doneB) begin
            checkOutput("pendingB", 32'(qB.size() > 0), 32'd1);
            if (qB.size() > 0) expB = qB.pop_front();
         end
         checkOutput("bcdA", 32'(bcdA), 32'(expA[4*DA-1:0]));
         checkOutput("bcdB", 32'(bcdB), 32'(expB[4*DB-1:0]));
`ifdef BCD_SEQ_OVF_DETECT_EN
         checkOutput("ovfA", 32'(ovfA), 32'(expA[16]));
         checkOutput("ovfB", 32'(ovfB), 32'(expB[16]));
`endif
         mResA <= expA;
         mResB <= expB;
      end
   end

   // Directed scenarios followed by a few random operands.
   initial begin
      int listB[8];
      listB = '{0, 9, 10, 99, 100, 57, 127, 101};

      repeat (2) @(posedge clk);
      #2;
      checkOutput("rstBusy", 32'(busyA), 32'd0);
      checkOutput("rstDone", 32'(doneA), 32'd0);
      checkOutput("rstBcd",  32'(bcdA),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus(0, 255, WA + 3);
      applyStimulus(0, 0,   WA + 3);
      applyStimulus(0, 99,  WA + 3);

      // Second start lands while busy and must be ignored.
      applyStimulus(0, 200, 3);
      applyStimulus(0, 7,   WA + 3);

      // Start held high: back-to-back conversions every WIDTH+1 cycles.
      @(posedge clk);
      #1;
      startA = 1'b1;
      binA   = 8'd42;
      repeat (30) @(posedge clk);
      #1;
      startA = 1'b0;
      repeat (WA + 3) @(posedge clk);

      // Asynchronous reset in the middle of a conversion.
      applyStimulus(0, 123, 4);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("midRstBusy", 32'(busyA), 32'd0);
      checkOutput("midRstDone", 32'(doneA), 32'd0);
      checkOutput("midRstBcd",  32'(bcdA),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(0, 123, WA + 3);

      for (int i = 0; i < 4; i++) applyStimulus(0, int'($urandom_range(0, 255)), WA + 3);

      foreach (listB[i]) applyStimulus(1, listB[i], WB + 3);
      for (int i = 0; i < 4; i++) applyStimulus(1, int'($urandom_range(0, 127)), WB + 3);

      repeat (4) @(posedge clk);
      #1;
      checkOutput("drainA", 32'(qA.size()), 32'd0);
      checkOutput("drainB", 32'(qB.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
